// File: rtl/gpr_writeback.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : gpr_writeback
// Purpose  : Writeback driver for the GPR write port; aligns load data and
//            issues a registered one-cycle register-file write command.
// Revision : 1.0 - initial release
// ============================================================================
module gpr_writeback #(
    parameter int TIMEOUT    = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_op,
    input  logic [4:0]            in_rd_addr,
    input  logic [DATA_WIDTH-1:0] in_alu_result,
    input  logic [1:0]            in_addr_lo,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [4:0]            rd_addr,
    output logic [DATA_WIDTH-1:0] rd_in,
    output logic [3:0]            rd_byte_w_en,
    output logic                  write,
    output logic                  err,
    output logic                  pending_valid,
    output logic [4:0]            pending_rd
);

    localparam logic [2:0] c_OP_ALU = 3'd0;
    localparam logic [2:0] c_OP_LB  = 3'd1;
    localparam logic [2:0] c_OP_LBU = 3'd2;
    localparam logic [2:0] c_OP_LH  = 3'd3;
    localparam logic [2:0] c_OP_LHU = 3'd4;
    localparam logic [2:0] c_OP_LW  = 3'd5;
    localparam logic [2:0] c_OP_LWL = 3'd6;
    localparam logic [2:0] c_OP_LWR = 3'd7;

    localparam int               c_CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_MEM = 2'd1,
        S_COMMIT   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2:0]           r_op;
    logic [4:0]           r_rd;
    logic [1:0]           r_k;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;

    logic [4:0]            r_rd_addr;
    logic [DATA_WIDTH-1:0] r_rd_in;
    logic [3:0]            r_en;
    logic                  r_write;
    logic                  r_err;

    logic [4:0]            w_cmd_rd;
    logic [DATA_WIDTH-1:0] w_cmd_data;
    logic [3:0]            w_cmd_en;
    logic                  w_cmd_write;
    logic                  w_cmd_err;

    logic                  w_accept;
    logic                  w_in_misaligned;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_align_data;
    logic [3:0]            w_align_en;

    assign in_ready = (r_state != S_WAIT_MEM);
    assign w_accept = in_valid & in_ready;

    always_comb begin
        w_in_misaligned = 1'b0;
        case (in_op)
            c_OP_LH, c_OP_LHU: w_in_misaligned = in_addr_lo[0];
            c_OP_LW:           w_in_misaligned = |in_addr_lo;
            default:           w_in_misaligned = 1'b0;
        endcase
    end

    // Load alignment uses the latched op and address bits of the waiting load.
    assign w_byte = mem_rdata[{r_k, 3'b000} +: 8];
    assign w_half = r_k[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        w_align_data = mem_rdata;
        w_align_en   = 4'b1111;
        case (r_op)
            c_OP_LB:  w_align_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            c_OP_LBU: w_align_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            c_OP_LH:  w_align_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            c_OP_LHU: w_align_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
            c_OP_LWL: begin
                // ~k equals 3-k for a 2-bit offset
                w_align_data = mem_rdata << {~r_k, 3'b000};
                w_align_en   = 4'b1111 << ~r_k;
            end
            c_OP_LWR: begin
                w_align_data = mem_rdata >> {r_k, 3'b000};
                w_align_en   = 4'b1111 >> r_k;
            end
            default: begin
                w_align_data = mem_rdata;
                w_align_en   = 4'b1111;
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cmd_rd    = 5'd0;
        w_cmd_data  = '0;
        w_cmd_en    = 4'b0000;
        w_cmd_write = 1'b0;
        w_cmd_err   = 1'b0;
        case (r_state)
            S_WAIT_MEM: begin
                if (mem_rvalid) begin
                    w_state_nxt = S_COMMIT;
                    w_cmd_rd    = r_rd;
                    w_cmd_data  = w_align_data;
                    w_cmd_en    = w_align_en;
                    w_cmd_write = |r_rd;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_COMMIT;
                    w_cmd_rd    = r_rd;
                    w_cmd_err   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            default: begin
                if (w_accept) begin
                    if (in_op == c_OP_ALU) begin
                        w_state_nxt = S_COMMIT;
                        w_cmd_rd    = in_rd_addr;
                        w_cmd_data  = in_alu_result;
                        w_cmd_en    = 4'b1111;
                        w_cmd_write = |in_rd_addr;
                    end else if (w_in_misaligned) begin
                        w_state_nxt = S_COMMIT;
                        w_cmd_rd    = in_rd_addr;
                        w_cmd_err   = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT_MEM;
                        w_cnt_nxt   = '0;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_op      <= c_OP_ALU;
            r_rd      <= 5'd0;
            r_k       <= 2'd0;
            r_rd_addr <= 5'd0;
            r_rd_in   <= '0;
            r_en      <= 4'b0000;
            r_write   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rd_addr <= w_cmd_rd;
            r_rd_in   <= w_cmd_data;
            r_en      <= w_cmd_en;
            r_write   <= w_cmd_write;
            r_err     <= w_cmd_err;
            if (w_accept) begin
                r_op <= in_op;
                r_rd <= in_rd_addr;
                r_k  <= in_addr_lo;
            end
        end
    end

    assign rd_addr       = r_rd_addr;
    assign rd_in         = r_rd_in;
    assign rd_byte_w_en  = r_en;
    assign write         = r_write;
    assign err           = r_err;
    assign pending_valid = (r_state != S_IDLE) && (r_rd != 5'd0);
    assign pending_rd    = pending_valid ? r_rd : 5'd0;

endmodule
`default_nettype wire

// File: tb/tb_gpr_writeback.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_gpr_writeback
// Purpose  : Directed self-checking bench for gpr_writeback with a queue of
//            expected register-file commands.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpr_writeback;

    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [3:0]  en;
        logic        wr;
        logic        er;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [4:0]  in_rd_addr;
    logic [31:0] in_alu_result;
    logic [1:0]  in_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_in;
    logic [3:0]  rd_byte_w_en;
    logic        write;
    logic        err;
    logic        pending_valid;
    logic [4:0]  pending_rd;

    int   n_pass  = 0;
    int   n_total = 0;
    int   n_fail  = 0;
    int   lat;
    exp_t sb[$];

    always #5 clk = ~clk;

    gpr_writeback #(.TIMEOUT(TIMEOUT), .DATA_WIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_rd_addr    (in_rd_addr),
        .in_alu_result (in_alu_result),
        .in_addr_lo    (in_addr_lo),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .rd_addr       (rd_addr),
        .rd_in         (rd_in),
        .rd_byte_w_en  (rd_byte_w_en),
        .write         (write),
        .err           (err),
        .pending_valid (pending_valid),
        .pending_rd    (pending_rd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk_err(input logic [4:0] rd);
        exp_t e;
        e.rd = rd; e.data = 32'd0; e.en = 4'd0; e.wr = 1'b0; e.er = 1'b1;
        return e;
    endfunction

    // Reference result built byte-by-byte from the little-endian word.
    function automatic exp_t model(input logic [2:0] op, input logic [4:0] rd,
                                   input logic [1:0] k, input logic [31:0] v);
        exp_t       e;
        logic [7:0] b [4];
        logic [15:0] h;
        int         kk;
        kk = int'(k);
        for (int i = 0; i < 4; i++) b[i] = v[8*i +: 8];
        h = k[1] ? {b[3], b[2]} : {b[1], b[0]};
        e.rd = rd; e.data = v; e.en = 4'hF; e.wr = (rd != 5'd0); e.er = 1'b0;
        case (op)
            3'd1: e.data = {{24{b[kk][7]}}, b[kk]};
            3'd2: e.data = {24'd0, b[kk]};
            3'd3: e.data = {{16{h[15]}}, h};
            3'd4: e.data = {16'd0, h};
            3'd6: begin
                e.data = 32'd0; e.en = 4'd0;
                for (int j = 0; j < 4; j++)
                    if (j + kk >= 3) begin
                        e.data[8*j +: 8] = b[j+kk-3];
                        e.en[j] = 1'b1;
                    end
            end
            3'd7: begin
                e.data = 32'd0; e.en = 4'd0;
                for (int j = 0; j < 4; j++)
                    if (j + kk <= 3) begin
                        e.data[8*j +: 8] = b[j+kk];
                        e.en[j] = 1'b1;
                    end
            end
            default: e.data = v;
        endcase
        return e;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [1:0] k);
        in_valid = 1'b1; in_op = op; in_rd_addr = rd; in_alu_result = alu; in_addr_lo = k;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_op = 3'd0; in_rd_addr = 5'd0; in_alu_result = 32'd0; in_addr_lo = 2'd0;
    endtask

    task automatic mem_resp(input logic [31:0] data);
        mem_rvalid = 1'b1; mem_rdata = data;
        @(posedge clk);
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = 32'd0;
    endtask

    task automatic wait_commit(input string tag, input int max, output int cycles);
        exp_t e;
        cycles = 0;
        while (!(write === 1'b1 || err === 1'b1) && cycles < max) begin
            @(negedge clk);
            cycles++;
        end
        if (write !== 1'b1 && err !== 1'b1) begin
            n_total++;
            n_fail++;
            $error("FAIL %s no_commit observed=none expected=commit_within_%0d", tag, max);
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            n_total++;
            n_fail++;
            $error("FAIL %s unexpected_commit observed=write%0b_err%0b expected=none", tag, write, err);
        end else begin
            e = sb.pop_front();
            check({tag, "_write"}, write, e.wr);
            check({tag, "_err"}, err, e.er);
            if (e.wr) begin
                check({tag, "_rd"}, rd_addr, e.rd);
                check({tag, "_data"}, rd_in, e.data);
                check({tag, "_en"}, rd_byte_w_en, e.en);
            end
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_rd_addr = 5'd0;
        in_alu_result = 32'd0; in_addr_lo = 2'd0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_write", write, 0);
        check("rst_err", err, 0);
        check("rst_pending", {pending_valid, pending_rd}, 0);
        check("rst_cmd", {rd_addr, rd_byte_w_en}, 0);
        check("rst_rd_in", rd_in, 0);

        // ALU write appears in the cycle right after accept
        sb.push_back(model(3'd0, 5'd5, 2'd0, 32'hDEADBEEF));
        issue(3'd0, 5'd5, 32'hDEADBEEF, 2'd0);
        check("alu_pending_valid", pending_valid, 1);
        check("alu_pending_rd", pending_rd, 5);
        wait_commit("alu", 3, lat);
        check("alu_latency", lat, 0);
        @(negedge clk);
        check("alu_write_drop", write, 0);
        check("alu_pending_drop", pending_valid, 0);

        // Sign/zero-extended byte loads
        issue(3'd1, 5'd3, 32'd0, 2'd1);
        check("lb_in_ready_wait", in_ready, 0);
        check("lb_pending_rd", pending_rd, 3);
        sb.push_back(model(3'd1, 5'd3, 2'd1, 32'h00008000));
        mem_resp(32'h00008000);
        wait_commit("lb", 3, lat);
        check("lb_latency", lat, 0);

        issue(3'd2, 5'd4, 32'd0, 2'd1);
        repeat (3) @(negedge clk);
        check("lbu_no_early_write", write, 0);
        sb.push_back(model(3'd2, 5'd4, 2'd1, 32'h00008000));
        mem_resp(32'h00008000);
        wait_commit("lbu", 3, lat);

        // Unaligned word halves
        issue(3'd6, 5'd6, 32'd0, 2'd1);
        sb.push_back(model(3'd6, 5'd6, 2'd1, 32'h11223344));
        mem_resp(32'h11223344);
        wait_commit("lwl", 3, lat);
        issue(3'd7, 5'd6, 32'd0, 2'd1);
        sb.push_back(model(3'd7, 5'd6, 2'd1, 32'h11223344));
        mem_resp(32'h11223344);
        wait_commit("lwr", 3, lat);

        // Halfword loads from the upper half
        issue(3'd3, 5'd8, 32'd0, 2'd2);
        sb.push_back(model(3'd3, 5'd8, 2'd2, 32'h80011234));
        mem_resp(32'h80011234);
        wait_commit("lh", 3, lat);
        issue(3'd4, 5'd8, 32'd0, 2'd2);
        sb.push_back(model(3'd4, 5'd8, 2'd2, 32'h80011234));
        mem_resp(32'h80011234);
        wait_commit("lhu", 3, lat);

        // Misaligned loads error out immediately
        sb.push_back(mk_err(5'd10));
        issue(3'd5, 5'd10, 32'd0, 2'd2);
        wait_commit("lw_misalign", 0, lat);
        @(negedge clk);
        check("lw_misalign_err_pulse", err, 0);
        sb.push_back(mk_err(5'd12));
        issue(3'd4, 5'd12, 32'd0, 2'd3);
        wait_commit("lhu_misalign", 0, lat);

        // Timeout with no rvalid; late rvalid afterwards is ignored
        sb.push_back(mk_err(5'd7));
        issue(3'd5, 5'd7, 32'd0, 2'd0);
        wait_commit("timeout", TIMEOUT + 4, lat);
        check("timeout_latency", lat, TIMEOUT);
        mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
        @(negedge clk);
        check("timeout_err_pulse", err, 0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("late_rvalid_write", write, 0);
        check("late_rvalid_in_ready", in_ready, 1);

        // rvalid on the final wait cycle beats the timeout
        issue(3'd5, 5'd11, 32'd0, 2'd0);
        repeat (TIMEOUT - 1) @(negedge clk);
        check("last_cycle_no_err", err, 0);
        check("last_cycle_in_ready", in_ready, 0);
        sb.push_back(model(3'd5, 5'd11, 2'd0, 32'hCAFEF00D));
        mem_resp(32'hCAFEF00D);
        wait_commit("rvalid_wins", 0, lat);

        // rd = 0 never writes and never reports pending
        issue(3'd0, 5'd0, 32'h00001234, 2'd0);
        check("rd0_write", write, 0);
        check("rd0_err", err, 0);
        check("rd0_pending", {pending_valid, pending_rd}, 0);

        // Back-to-back ALU ops: one write per cycle
        sb.push_back(model(3'd0, 5'd1, 2'd0, 32'h00000001));
        issue(3'd0, 5'd1, 32'h00000001, 2'd0);
        wait_commit("b2b_0", 0, lat);
        sb.push_back(model(3'd0, 5'd2, 2'd0, 32'h22222222));
        issue(3'd0, 5'd2, 32'h22222222, 2'd0);
        wait_commit("b2b_1", 0, lat);
        check("b2b_pending_rd", pending_rd, 2);
        sb.push_back(model(3'd0, 5'd31, 2'd0, 32'hFFFFFFFF));
        issue(3'd0, 5'd31, 32'hFFFFFFFF, 2'd0);
        wait_commit("b2b_2", 0, lat);

        // Reset during WAIT_MEM drops the load
        issue(3'd5, 5'd9, 32'd0, 2'd0);
        check("rstmid_pending_rd", pending_rd, 9);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstmid_in_ready", in_ready, 1);
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("rstmid_write", write, 0);
        check("rstmid_err", err, 0);
        check("rstmid_pending", pending_valid, 0);
        @(negedge clk);
        check("rstmid_write_later", write, 0);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpr_writeback.md
# gpr_writeback

Writeback-stage driver for the general-purpose register file's write port. Accepts one retiring instruction at a time from the MEM stage, waits for load data from the data memory where needed, aligns and sign/zero-extends it, and presents a one-cycle `rd_addr`/`rd_in`/`rd_byte_w_en`/`write` command to the register file. It also exports the in-flight destination register so the hazard logic can stall dependent readers.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum WAIT_MEM cycles before the load is abandoned.
- `DATA_WIDTH`, 32: fixed at 32; byte lanes assume 4 bytes.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: MEM stage presents an instruction.
- `in_ready` output 1: block can accept this cycle.
- `in_op` input 3: 0 ALU, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR.
- `in_rd_addr` input 5: destination register.
- `in_alu_result` input 32: result for ALU ops.
- `in_addr_lo` input 2: low effective-address bits for loads.
- `mem_rvalid` input 1: load data valid.
- `mem_rdata` input 32: little-endian load word.
- `rd_addr` output 5, `rd_in` output 32, `rd_byte_w_en` output 4, `write` output 1: register-file write command.
- `err` output 1: one-cycle pulse, misaligned load or timeout.
- `pending_valid` output 1, `pending_rd` output 5: in-flight destination.

## Operation
- States: IDLE, WAIT_MEM, COMMIT. `in_ready` = 1 in IDLE and COMMIT, 0 in WAIT_MEM.
- Accept (`in_valid & in_ready` at an edge): latch op, rd, addr_lo, alu_result. ALU goes to COMMIT. A misaligned load goes to COMMIT with error flagged: LH/LHU with `addr_lo[0]`=1, or LW with `addr_lo`≠0. Every other load goes to WAIT_MEM with the timeout counter cleared.
- WAIT_MEM: `mem_rvalid` captures aligned data and goes to COMMIT. Otherwise the counter increments. When the counter reaches TIMEOUT-1 with no rvalid, go to COMMIT with error. If rvalid arrives in the same cycle, rvalid wins.
- COMMIT lasts exactly one cycle and drives the outputs. With an accept in this cycle, follow the IDLE accept rules; otherwise go to IDLE.
- Output values in COMMIT:
  - `write` = 1 only if there is no error and the rd is nonzero.
  - `err` = error flag.
  - All command outputs are 0 outside COMMIT.
- Alignment, with k = addr_lo and B(i) = `mem_rdata` byte i:
  - ALU: data = alu_result, en = 1111.
  - LB/LBU: B(k), sign- or zero-extended, en = 1111.
  - LH/LHU: halfword k[1], sign- or zero-extended, en = 1111.
  - LW: word, en = 1111.
  - LWL: data = rdata << 8·(3−k); en = 1000, 1100, 1110, 1111 for k = 0..3.
  - LWR: data = rdata >> 8·k; en = 1111, 0111, 0011, 0001 for k = 0..3.
- `pending_valid` = 1 from the cycle after accept through the COMMIT cycle inclusive, with `pending_rd` = latched rd. It stays 1 across back-to-back accepts. `pending_rd` = 0 when not pending. `pending_valid` = 0 when rd = 0.
- `mem_rvalid` outside WAIT_MEM is ignored.
- Reset, including mid-WAIT_MEM: state goes to IDLE and the in-flight instruction is dropped with no write and no err. All outputs are 0 except `in_ready` = 1.

## Timing
- Command outputs are registered and become visible the cycle after the deciding edge. The register file samples them on the falling edge inside that cycle.
- ALU latency: accept at edge N gives `write` high during cycle N+1.
- Load latency: rvalid sampled at edge M gives `write` high during cycle M+1. The minimum load latency is 2 cycles from accept.
- Timeout: with no rvalid after accept at edge N, `err` pulses during cycle N+TIMEOUT+1.
- Back-to-back ALU ops sustain one write per cycle.

## Test plan
- Reset, then ALU op rd=5, result 0xDEADBEEF, accepted at edge N -> cycle N+1: write=1, rd_addr=5, rd_in=0xDEADBEEF, en=1111; cycle N+2: write=0.
- LB k=1 then LBU k=1, rdata 0x00008000 -> rd_in 0xFFFFFF80, then 0x00000080, both with en=1111.
- LWL k=1 rdata 0x11223344 -> rd_in 0x33440000, en=1100; LWR k=1 -> rd_in 0x00112233, en=0111.
- LW k=2 -> next cycle err=1, write=0. LW with no rvalid and TIMEOUT=16 -> err pulse in cycle N+17; a later rvalid is ignored.
- ALU rd=0 -> write=0, pending_valid=0. Three back-to-back ALU ops -> three consecutive write cycles.
- Reset asserted mid-WAIT_MEM, then rvalid -> no write, no err, in_ready=1, pending_valid=0.
